ask_demodulator: RTL and testbench
==================================

ASK_DEMODULATOR -- requirements
Module: ask_demodulator

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  WIN_LEN, 4096, carrier-detect window length in i_clk cycles (power of two, 16..65536).
  EDGE_THRESH, 4, minimum rising edges per window to declare carrier present (1..255).
  BIT_LEN, 16384, bit period in i_clk cycles (>= 2*WIN_LEN).
REQ-002 Ports, one per line: name, direction, width, meaning.
  i_clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
  i_rst  input  1  reset, synchronous, active-high.
  i_rx  input  1  asynchronous comparator output of the RC-filtered ASK line (toggles at carrier rate when the carrier is on, static when it is off).
  o_carrier  output  1  registered carrier-present flag.
  o_byte  output  8  last received data byte.
  o_byte_valid  output  1  one-cycle strobe, o_byte valid.
  o_frame_err  output  1  one-cycle strobe, stop bit carried carrier.
  o_clk_en  output  1  constant 1.
  o_byte_oe  output  8  constant all-ones.

Function
REQ-003 i_rx SHALL pass a 2-flop synchronizer; a rising edge is sync[1]=1 and prior-cycle sync[1]=0.
REQ-004 A free-running window counter SHALL count 0..WIN_LEN-1 and wrap; an 8-bit edge counter SHALL saturate at 255.
REQ-005 On the window's last cycle o_carrier SHALL load (edges >= EDGE_THRESH), counting an edge occurring in that same cycle, and the edge counter SHALL clear.
REQ-006 Frame format: idle = no carrier; start bit = carrier; 8 data bits LSB first (carrier = 1); stop bit = no carrier.
REQ-007 FSM states IDLE, START, DATA, STOP; a bit-timer counts 0..BIT_LEN-1.
REQ-008 IDLE: on o_carrier 0->1, go to START and clear the bit-timer.
REQ-009 START: at bit-timer = BIT_LEN/2-1, go to DATA if o_carrier=1, else back to IDLE with no strobe (false start).
REQ-010 DATA: sample o_carrier every BIT_LEN cycles after the start midpoint into a shift register; after the 8th sample go to STOP.
REQ-011 STOP: sample after a further BIT_LEN cycles; if o_carrier=0, update o_byte and pulse o_byte_valid for one cycle; if 1, pulse o_frame_err for one cycle and leave o_byte unchanged; in both cases go to IDLE.
REQ-012 After a frame error, IDLE SHALL wait for a 1->0->1 carrier transition before accepting a new start.
REQ-013 o_byte_valid and o_frame_err SHALL never be asserted in the same cycle.
REQ-014 Latency: strobe asserted exactly 9*BIT_LEN + BIT_LEN/2 cycles after the START entry cycle.

Reset
REQ-015 While i_rst=1 at a clock edge: FSM=IDLE, all counters 0, synchronizer 0, o_carrier=0, o_byte=8'h00, strobes 0.
REQ-016 Reset asserted mid-frame SHALL abort the frame with no strobe; the first frame after release SHALL decode normally.

Configuration
REQ-017 With ASK_DEMOD_GLITCH_FILTER_EN defined, a 3-tap majority filter SHALL follow the synchronizer (+1 cycle edge latency; single-cycle pulses rejected); without it, edges come directly from sync[1].

Structure
REQ-018 A shared package SHALL hold the FSM state enum, the frame bit count (8), and default WIN_LEN/EDGE_THRESH/BIT_LEN.
REQ-019 Carrier detection (REQ-003..005, REQ-017) SHALL be sub-module ask_carrier_detect; the framing FSM stays in ask_demodulator.

Verification
REQ-020 Square wave on i_rx with a 260-cycle period for one full window -> o_carrier=1 at that window's end; static i_rx for one window -> o_carrier=0.
REQ-021 Frame 0xA5 at BIT_LEN=16384 with carrier period 1024 -> o_byte=8'hA5 with a single o_byte_valid pulse, no o_frame_err.
REQ-022 Start burst of 4000 cycles then silence -> FSM returns to IDLE with no strobe.
REQ-023 Frame 0x3C with carrier held through the stop bit -> o_frame_err pulse, o_byte keeps its previous value, and the next valid frame 0x11 is decoded.
REQ-024 i_rst pulsed during data bit 4, then frame 0x7E sent -> no strobe for the aborted frame, then o_byte=8'h7E.
REQ-025 With ASK_DEMOD_GLITCH_FILTER_EN defined, 1-cycle i_rx pulses every 100 cycles -> o_carrier stays 0; without the macro -> o_carrier=1.

Source files
------------

// File: rtl/ask_demodulator_pkg.sv
// ask_demodulator_pkg: shared types and defaults for the ASK demodulator.
package ask_demodulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    localparam int FRAME_BITS      = 8;
    localparam int DEF_WIN_LEN     = 4096;
    localparam int DEF_EDGE_THRESH = 4;
    localparam int DEF_BIT_LEN     = 16384;

endpackage

// File: rtl/ask_demodulator_carrier_detect.sv
// ask_carrier_detect: synchronizes the comparator output, counts rising edges
// over a fixed window and flags carrier presence at each window end.
// Optional feature: ASK_DEMOD_GLITCH_FILTER_EN inserts a 3-tap majority
// filter after the synchronizer, rejecting single-cycle pulses.
module ask_carrier_detect
    import ask_demodulator_pkg::*;
#(
    parameter int WIN_LEN     = DEF_WIN_LEN,
    parameter int EDGE_THRESH = DEF_EDGE_THRESH
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_carrier
);

    localparam int WW = $clog2(WIN_LEN);

    logic [1:0]    sync_q, sync_d;
    logic          lvl_prev_q, lvl_prev_d;
    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [7:0]    edge_cnt_q, edge_cnt_d;
    logic          carrier_q, carrier_d;
    logic          lvl;
    logic          rise;
    logic          win_last;
    logic [8:0]    edges_now;
    logic [7:0]    edges_sat;

`ifdef ASK_DEMOD_GLITCH_FILTER_EN
    logic [1:0] tap_q, tap_d;

    // Majority of the current and two previous synchronized samples.
    always_comb begin
        tap_d = {tap_q[0], sync_q[1]};
        lvl   = (sync_q[1] & tap_q[0]) | (sync_q[1] & tap_q[1]) | (tap_q[0] & tap_q[1]);
    end

    // Filter tap registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) tap_q <= '0;
        else       tap_q <= tap_d;
    end
`else
    // Edges are taken straight from the synchronizer output.
    always_comb begin
        lvl = sync_q[1];
    end
`endif

    // Edge detection, window counting and carrier decision.
    always_comb begin
        sync_d     = {sync_q[0], i_rx};
        lvl_prev_d = lvl;
        rise       = lvl & ~lvl_prev_q;
        win_last   = (win_cnt_q == WW'(WIN_LEN - 1));
        win_cnt_d  = win_last ? '0 : win_cnt_q + WW'(1);
        edges_now  = {1'b0, edge_cnt_q} + {8'b0, rise};
        edges_sat  = edges_now[8] ? 8'hFF : edges_now[7:0];
        edge_cnt_d = win_last ? 8'h00 : edges_sat;
        carrier_d  = win_last ? (edges_sat >= 8'(EDGE_THRESH)) : carrier_q;
    end

    // Detector state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            carrier_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            lvl_prev_q <= lvl_prev_d;
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            carrier_q  <= carrier_d;
        end
    end

    assign o_carrier = carrier_q;

endmodule

// File: rtl/ask_demodulator.sv
// ask_demodulator: on/off-keyed UART-style receiver. Carrier presence is
// detected by ask_carrier_detect and framed here (start, 8 data LSB first,
// stop = no carrier). Optional feature ASK_DEMOD_GLITCH_FILTER_EN lives in
// the carrier detector.
//
// state | meaning
// IDLE  | waiting for carrier 0->1 (after a frame error, first needs 1->0)
// START | timing to the start-bit midpoint, rejecting false starts
// DATA  | sampling 8 data bits, one per bit period
// STOP  | sampling the stop bit, then strobing byte or frame error
module ask_demodulator
    import ask_demodulator_pkg::*;
#(
    parameter int WIN_LEN     = DEF_WIN_LEN,
    parameter int EDGE_THRESH = DEF_EDGE_THRESH,
    parameter int BIT_LEN     = DEF_BIT_LEN
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_carrier,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_clk_en,
    output logic [7:0] o_byte_oe
);

    localparam int TW = $clog2(BIT_LEN);
    localparam int CW = $clog2(FRAME_BITS);

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          car_prev_q;
    logic          err_wait_q, err_wait_d;
    logic          carrier;

    ask_carrier_detect #(
        .WIN_LEN     (WIN_LEN),
        .EDGE_THRESH (EDGE_THRESH)
    ) u_carrier_detect (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rx      (i_rx),
        .o_carrier (carrier)
    );

    // Framing FSM next-state, bit timing and strobe generation.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q + TW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        err_wait_d = err_wait_q;
        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (err_wait_q) begin
                    if (!carrier) err_wait_d = 1'b0;
                end else if (carrier && !car_prev_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tmr_q == TW'(BIT_LEN / 2 - 1)) begin
                    tmr_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = carrier ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (tmr_q == TW'(BIT_LEN - 1)) begin
                    tmr_d     = '0;
                    shift_d   = {carrier, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(FRAME_BITS - 1)) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tmr_q == TW'(BIT_LEN - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                    if (!carrier) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d     = 1'b1;
                        err_wait_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Framing state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            car_prev_q <= 1'b0;
            err_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            car_prev_q <= carrier;
            err_wait_q <= err_wait_d;
        end
    end

    assign o_carrier    = carrier;
    assign o_byte       = byte_q;
    assign o_byte_valid = valid_q;
    assign o_frame_err  = ferr_q;
    assign o_clk_en     = 1'b1;
    assign o_byte_oe    = 8'hFF;

endmodule

// File: tb/tb_ask_demodulator.sv
// tb_ask_demodulator: frame tests on a scaled instance, carrier-detect tests
// on a default-parameter instance, with a queue-based scoreboard.
module tb_ask_demodulator;
    import ask_demodulator_pkg::*;

    localparam int W  = 32;
    localparam int TH = 4;
    localparam int B  = 256;
    localparam int H  = B / 2;
    localparam int DW = DEF_WIN_LEN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // scaled instance
    logic       rst, rx;
    logic       car, bv, fe, cen;
    logic [7:0] byt, boe;
    // default instance
    logic       rst_d, rx_d;
    logic       car_d, bv_d, fe_d, cen_d;
    logic [7:0] byt_d, boe_d;

    ask_demodulator #(.WIN_LEN(W), .EDGE_THRESH(TH), .BIT_LEN(B)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx(rx), .o_carrier(car), .o_byte(byt),
        .o_byte_valid(bv), .o_frame_err(fe), .o_clk_en(cen), .o_byte_oe(boe));

    ask_demodulator dut_def (
        .i_clk(clk), .i_rst(rst_d), .i_rx(rx_d), .o_carrier(car_d), .o_byte(byt_d),
        .o_byte_valid(bv_d), .o_frame_err(fe_d), .o_clk_en(cen_d), .o_byte_oe(boe_d));

    typedef struct {
        logic [7:0] b;
        logic       err;
        longint     lo;
        longint     hi;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] last_good = 8'h00;
    int         checks = 0;
    int         errors = 0;
    longint     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // Monitor: every strobe pops one expectation.
    always @(negedge clk) begin
        if (!rst && (bv || fe)) begin
            check("strobe_exclusive", {31'b0, bv & fe}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b byte=%02h at cycle %0d, expected none",
                         bv, fe, byt, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_kind_err", {31'b0, fe}, {31'b0, mon_e.err});
                check("strobe_byte", {24'b0, byt}, {24'b0, mon_e.b});
                checks++;
                if (cyc < mon_e.lo || cyc > mon_e.hi) begin
                    errors++;
                    $display("FAIL strobe_latency: cycle %0d, expected %0d..%0d", cyc, mon_e.lo, mon_e.hi);
                end
            end
        end
    end

    task automatic send_level(input logic lvl, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rx = lvl ? c[1] : 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_car);
        exp_t e;
        e.b   = stop_car ? last_good : d;
        e.err = stop_car;
        e.lo  = cyc + 9 * B + H;
        e.hi  = cyc + 9 * B + H + 2 * W + 10;
        sb.push_back(e);
        if (!stop_car) last_good = d;
        send_level(1'b1, B);
        for (int i = 0; i < 8; i++) send_level(d[i], B);
        send_level(stop_car, B);
        send_level(1'b0, 2 * B);
    endtask

    task automatic run_frames();
        logic [7:0] ab;
        rst = 1'b1;
        rx  = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_carrier", {31'b0, car}, 32'd0);
        check("rst_byte", {24'b0, byt}, 32'h00);
        check("rst_valid", {31'b0, bv}, 32'd0);
        check("rst_ferr", {31'b0, fe}, 32'd0);
        check("clk_en", {31'b0, cen}, 32'd1);
        check("byte_oe", {24'b0, boe}, 32'hFF);
        rst = 1'b0;
        send_level(1'b0, 2 * B);
        send_frame(8'hA5, 1'b0);
        // false start: short burst, then silence
        send_level(1'b1, 2 * W);
        send_level(1'b0, 3 * B);
        check("false_start_byte", {24'b0, byt}, 32'hA5);
        send_frame(8'h5A, 1'b0);
        send_frame(8'h3C, 1'b1);
        check("ferr_byte_kept", {24'b0, byt}, 32'h5A);
        send_frame(8'h11, 1'b0);
        // abort frame 0x42 with a reset during data bit 4
        ab = 8'h42;
        send_level(1'b1, B);
        for (int i = 0; i < 4; i++) send_level(ab[i], B);
        send_level(ab[4], H);
        rx  = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_byte", {24'b0, byt}, 32'h00);
        check("abort_carrier", {31'b0, car}, 32'd0);
        rst = 1'b0;
        last_good = 8'h00;
        send_level(1'b0, 2 * B);
        send_frame(8'h7E, 1'b0);
        repeat (B) @(negedge clk);
        check("final_byte", {24'b0, byt}, 32'h7E);
        check("scoreboard_drained", sb.size(), 32'd0);
    endtask

    task automatic run_carrier();
        int len;
        len   = 3 * DW + DW / 2;
        rst_d = 1'b1;
        rx_d  = 1'b0;
        repeat (4) @(negedge clk);
        check("def_rst_carrier", {31'b0, car_d}, 32'd0);
        rst_d = 1'b0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            rx_d = ((c % 260) < 130);
        end
        check("square260_carrier", {31'b0, car_d}, 32'd1);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            rx_d = 1'b0;
        end
        check("static_carrier", {31'b0, car_d}, 32'd0);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            rx_d = ((c % 100) == 0);
        end
`ifdef ASK_DEMOD_GLITCH_FILTER_EN
        check("glitch_carrier", {31'b0, car_d}, 32'd0);
`else
        check("glitch_carrier", {31'b0, car_d}, 32'd1);
`endif
    endtask

    initial begin
        rst   = 1'b1;
        rx    = 1'b0;
        rst_d = 1'b1;
        rx_d  = 1'b0;
        fork
            run_frames();
            run_carrier();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
